sayuru_mem_arbiter: RTL and testbench

SAYURU_MEM_ARBITER -- requirements
Module: sayuru_mem_arbiter

---
 rtl/sayuru_arb_pkg.sv | 33 +++
 rtl/sayuru_rr_pick.sv | 30 +++
 rtl/sayuru_mem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_sayuru_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sayuru_arb_pkg.sv
// ----------------------------------------------------------------------------
// sayuru_arb_pkg
// Shared types and constants for the two-port memory arbiter.
//   ARB_PORTS   : number of requester ports (2)
//   ARB_ADDR_W  : address width the command struct is built with
//   ARB_DATA_W  : data width the command struct is built with
//   arb_state_e : arbiter FSM states
//   arb_cmd_t   : captured requester command (addr, we, be, wdata)
// The arbiter's ADDR_WIDTH/DATA_WIDTH parameters default to ARB_ADDR_W and
// ARB_DATA_W; the command struct is sized from these package constants, so
// a different bus width is obtained by editing them here.
// ----------------------------------------------------------------------------
package sayuru_arb_pkg;

    localparam int ARB_PORTS  = 2;
    localparam int ARB_ADDR_W = 16;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_BE_W   = ARB_DATA_W / 8;

    typedef enum logic [1:0] {
        ARB_IDLE        = 2'd0,
        ARB_WAIT_GNT    = 2'd1,
        ARB_WAIT_RVALID = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic                  we;
        logic [ARB_BE_W-1:0]   be;
        logic [ARB_DATA_W-1:0] wdata;
    } arb_cmd_t;

endpackage

// File: rtl/sayuru_rr_pick.sv
// ----------------------------------------------------------------------------
// sayuru_rr_pick
// Combinational two-port round-robin winner selection.
//   i_req        : request vector, bit N = requester N
//   i_last_grant : index of the port that completed the previous transaction
//   o_winner     : selected port index
//   o_valid      : at least one request is present
// A lone requester always wins; under contention the port that was not
// served last wins.
// ----------------------------------------------------------------------------
module sayuru_rr_pick
    import sayuru_arb_pkg::*;
(
    input  logic [ARB_PORTS-1:0] i_req,
    input  logic                 i_last_grant,
    output logic                 o_winner,
    output logic                 o_valid
);

    always_comb begin
        o_winner = 1'b0;
        o_valid  = |i_req;
        if (i_req[0] && i_req[1]) begin
            o_winner = ~i_last_grant;
        end else if (i_req[1]) begin
            o_winner = 1'b1;
        end
    end

endmodule

// File: rtl/sayuru_mem_arbiter.sv
// ----------------------------------------------------------------------------
// sayuru_mem_arbiter
// Two-requester arbiter in front of a single memory (cache) data port, one
// transaction outstanding at a time.
//   clk_i, rst_ni                : clock, asynchronous active-low reset
//   pN_data_req/addr/we/be/wdata : requester N command (req held until gnt)
//   pN_data_gnt_o/rvalid_o/rdata : grant / response forwarded to requester N
//   out_data_req/addr/we/be/wdata: registered command toward memory
//   out_data_gnt/rvalid/rdata    : memory handshake and read data
// Optional feature, macro SAYURU_ARB_PERF_EN: adds grant_count_p0,
// grant_count_p1 (forwarded grants) and contention_count (IDLE cycles with
// both requests high).
// ----------------------------------------------------------------------------
module sayuru_mem_arbiter
    import sayuru_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ARB_ADDR_W,
    parameter int DATA_WIDTH = ARB_DATA_W
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    p0_data_req_i,
    input  logic [ADDR_WIDTH-1:0]   p0_data_addr_i,
    input  logic                    p0_data_we_i,
    input  logic [DATA_WIDTH/8-1:0] p0_data_be_i,
    input  logic [DATA_WIDTH-1:0]   p0_data_wdata_i,
    output logic                    p0_data_gnt_o,
    output logic                    p0_data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   p0_data_rdata_o,

    input  logic                    p1_data_req_i,
    input  logic [ADDR_WIDTH-1:0]   p1_data_addr_i,
    input  logic                    p1_data_we_i,
    input  logic [DATA_WIDTH/8-1:0] p1_data_be_i,
    input  logic [DATA_WIDTH-1:0]   p1_data_wdata_i,
    output logic                    p1_data_gnt_o,
    output logic                    p1_data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   p1_data_rdata_o,

    output logic                    out_data_req_o,
    output logic [ADDR_WIDTH-1:0]   out_data_addr_o,
    output logic                    out_data_we_o,
    output logic [DATA_WIDTH/8-1:0] out_data_be_o,
    output logic [DATA_WIDTH-1:0]   out_data_wdata_o,
    input  logic                    out_data_gnt_i,
    input  logic                    out_data_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   out_data_rdata_i
`ifdef SAYURU_ARB_PERF_EN
    ,
    output logic [31:0]             grant_count_p0,
    output logic [31:0]             grant_count_p1,
    output logic [31:0]             contention_count
`endif
);

    arb_state_e r_state;
    arb_state_e w_state_nxt;
    logic       r_winner;
    logic       r_last_grant;
    arb_cmd_t   r_cmd;

    logic       w_pick_winner;
    logic       w_pick_valid;
    logic       w_fwd_gnt;
    logic       w_fwd_rvalid;
    arb_cmd_t   w_cmd_p0;
    arb_cmd_t   w_cmd_p1;

    assign w_cmd_p0 = {p0_data_addr_i, p0_data_we_i, p0_data_be_i, p0_data_wdata_i};
    assign w_cmd_p1 = {p1_data_addr_i, p1_data_we_i, p1_data_be_i, p1_data_wdata_i};

    sayuru_rr_pick u_pick (
        .i_req        ({p1_data_req_i, p0_data_req_i}),
        .i_last_grant (r_last_grant),
        .o_winner     (w_pick_winner),
        .o_valid      (w_pick_valid)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Memory handshakes only reach a requester while the FSM expects them;
    // anything seen in IDLE (e.g. a response to a transaction abandoned by
    // reset) is dropped. An rvalid arriving with the gnt completes at once.
    always_comb begin
        w_state_nxt  = r_state;
        w_fwd_gnt    = 1'b0;
        w_fwd_rvalid = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = ARB_WAIT_GNT;
                end
            end
            ARB_WAIT_GNT: begin
                w_fwd_gnt = out_data_gnt_i;
                if (out_data_gnt_i) begin
                    w_fwd_rvalid = out_data_rvalid_i;
                    w_state_nxt  = out_data_rvalid_i ? ARB_IDLE : ARB_WAIT_RVALID;
                end
            end
            ARB_WAIT_RVALID: begin
                w_fwd_rvalid = out_data_rvalid_i;
                if (out_data_rvalid_i) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    // The command is captured once in IDLE, so a requester dropping req
    // before its grant does not disturb the memory-side transaction.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_winner     <= 1'b0;
            r_last_grant <= 1'b1;
            r_cmd        <= '0;
        end else begin
            if (r_state == ARB_IDLE && w_pick_valid) begin
                r_winner <= w_pick_winner;
                r_cmd    <= w_pick_winner ? w_cmd_p1 : w_cmd_p0;
            end
            if (w_fwd_gnt) begin
                r_cmd <= '0;
            end
            if (w_fwd_rvalid) begin
                r_last_grant <= r_winner;
            end
        end
    end

    assign out_data_req_o   = (r_state == ARB_WAIT_GNT);
    assign out_data_addr_o  = r_cmd.addr;
    assign out_data_we_o    = r_cmd.we;
    assign out_data_be_o    = r_cmd.be;
    assign out_data_wdata_o = r_cmd.wdata;

    assign p0_data_gnt_o    = w_fwd_gnt && !r_winner;
    assign p1_data_gnt_o    = w_fwd_gnt &&  r_winner;
    assign p0_data_rvalid_o = w_fwd_rvalid && !r_winner;
    assign p1_data_rvalid_o = w_fwd_rvalid &&  r_winner;
    assign p0_data_rdata_o  = p0_data_rvalid_o ? out_data_rdata_i : '0;
    assign p1_data_rdata_o  = p1_data_rvalid_o ? out_data_rdata_i : '0;

`ifdef SAYURU_ARB_PERF_EN
    logic [31:0] r_grant_cnt_p0;
    logic [31:0] r_grant_cnt_p1;
    logic [31:0] r_contention_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_grant_cnt_p0   <= '0;
            r_grant_cnt_p1   <= '0;
            r_contention_cnt <= '0;
        end else begin
            if (p0_data_gnt_o) begin
                r_grant_cnt_p0 <= r_grant_cnt_p0 + 32'd1;
            end
            if (p1_data_gnt_o) begin
                r_grant_cnt_p1 <= r_grant_cnt_p1 + 32'd1;
            end
            if (r_state == ARB_IDLE && p0_data_req_i && p1_data_req_i) begin
                r_contention_cnt <= r_contention_cnt + 32'd1;
            end
        end
    end

    assign grant_count_p0   = r_grant_cnt_p0;
    assign grant_count_p1   = r_grant_cnt_p1;
    assign contention_count = r_contention_cnt;
`endif

endmodule

// File: tb/tb_sayuru_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sayuru_mem_arbiter
// Two requester processes issue random commands; a memory process answers
// with random grant/response delays and pushes the expected grant owner and
// read response into queues; a monitor pops and compares whenever the DUT
// presents a grant or response. Arbitration order is predicted from the
// round-robin rule applied to the requests present when the arbiter decided.
// ----------------------------------------------------------------------------
module tb_sayuru_mem_arbiter;

    localparam int NTX = 30;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [15:0] p0_addr, p1_addr;
    logic [3:0]  p0_be, p1_be;
    logic [31:0] p0_wdata, p1_wdata;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic        out_req, out_we, out_gnt, out_rvalid;
    logic [15:0] out_addr;
    logic [3:0]  out_be;
    logic [31:0] out_wdata, out_rdata;
`ifdef SAYURU_ARB_PERF_EN
    logic [31:0] gc0, gc1, cc;
`endif

    always #5 clk = ~clk;

    sayuru_mem_arbiter dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .p0_data_req_i     (p0_req),
        .p0_data_addr_i    (p0_addr),
        .p0_data_we_i      (p0_we),
        .p0_data_be_i      (p0_be),
        .p0_data_wdata_i   (p0_wdata),
        .p0_data_gnt_o     (p0_gnt),
        .p0_data_rvalid_o  (p0_rvalid),
        .p0_data_rdata_o   (p0_rdata),
        .p1_data_req_i     (p1_req),
        .p1_data_addr_i    (p1_addr),
        .p1_data_we_i      (p1_we),
        .p1_data_be_i      (p1_be),
        .p1_data_wdata_i   (p1_wdata),
        .p1_data_gnt_o     (p1_gnt),
        .p1_data_rvalid_o  (p1_rvalid),
        .p1_data_rdata_o   (p1_rdata),
        .out_data_req_o    (out_req),
        .out_data_addr_o   (out_addr),
        .out_data_we_o     (out_we),
        .out_data_be_o     (out_be),
        .out_data_wdata_o  (out_wdata),
        .out_data_gnt_i    (out_gnt),
        .out_data_rvalid_i (out_rvalid),
        .out_data_rdata_i  (out_rdata)
`ifdef SAYURU_ARB_PERF_EN
        ,
        .grant_count_p0    (gc0),
        .grant_count_p1    (gc1),
        .contention_count  (cc)
`endif
    );

    typedef struct {
        int          port;
        logic [31:0] data;
    } rsp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          gq[$];
    rsp_t        rq[$];
    int          ord[$];
    int          m_last;
    int          m_gcnt[2];
    logic [15:0] pend_addr[2];
    logic        pend_we[2];
    logic [3:0]  pend_be[2];
    logic [31:0] pend_wdata[2];
    logic        done0, done1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_port(input int p, input logic r, input logic [15:0] a,
                            input logic w, input logic [3:0] b, input logic [31:0] d);
        if (p == 0) begin
            p0_req = r; p0_addr = a; p0_we = w; p0_be = b; p0_wdata = d;
        end else begin
            p1_req = r; p1_addr = a; p1_we = w; p1_be = b; p1_wdata = d;
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic run_txn(input int p, input logic [15:0] a, input logic w,
                           input logic [3:0] b, input logic [31:0] d);
        logic got_g, got_r;
        pend_addr[p] = a; pend_we[p] = w; pend_be[p] = b; pend_wdata[p] = d;
        set_port(p, 1'b1, a, w, b, d);
        got_g = 1'b0;
        got_r = 1'b0;
        for (int k = 0; k < 200 && !got_g; k++) begin
            @(negedge clk);
            got_g = (p == 0) ? p0_gnt : p1_gnt;
            got_r = (p == 0) ? p0_rvalid : p1_rvalid;
        end
        chk($sformatf("p%0d_gnt_seen", p), got_g, 1'b1);
        @(posedge clk); #1;
        set_port(p, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0);
        if (!got_r) begin
            for (int k = 0; k < 200 && !got_r; k++) begin
                @(negedge clk);
                got_r = (p == 0) ? p0_rvalid : p1_rvalid;
            end
            chk($sformatf("p%0d_rvalid_seen", p), got_r, 1'b1);
            @(posedge clk); #1;
        end
    endtask

    task automatic run_requester(input int p);
        @(posedge clk); #1;
        if (p == 0) begin
            run_txn(0, 16'h0040, 1'b0, 4'hF, 32'h0);
        end else begin
            run_txn(1, 16'h0100, 1'b1, 4'hF, 32'h12345678);
        end
        run_txn(p, 16'($urandom), 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
        for (int i = 0; i < NTX; i++) begin
            repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
            run_txn(p, 16'($urandom), 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
        end
        if (p == 0) done0 = 1'b1; else done1 = 1'b1;
    endtask

    task automatic run_memory();
        int          idx, win, gd, rd;
        logic [1:0]  req_prev;
        logic [31:0] data;
        idx = 0;
        req_prev = 2'b00;
        while (!(done0 && done1)) begin
            @(negedge clk);
            if (out_req) begin
                if (req_prev == 2'b11) win = (m_last == 1) ? 0 : 1;
                else if (req_prev == 2'b10) win = 1;
                else win = 0;
                chk("arb_had_request", {62'd0, req_prev != 2'b00}, 64'd1);
                m_last = win;
                ord.push_back(win);
                chk("cmd_addr", out_addr, pend_addr[win]);
                chk("cmd_we", out_we, pend_we[win]);
                chk("cmd_be", out_be, pend_be[win]);
                chk("cmd_wdata", out_wdata, pend_wdata[win]);
                if (idx == 0) begin gd = 1; rd = 3; data = 32'hDEADBEEF; end
                else if (idx == 1) begin gd = 0; rd = 0; data = 32'hA5A5A5A5; end
                else begin gd = $urandom_range(0, 3); rd = $urandom_range(0, 3); data = $urandom; end
                repeat (gd) @(posedge clk);
                @(posedge clk); #1;
                out_gnt = 1'b1;
                gq.push_back(win);
                m_gcnt[win]++;
                if (rd == 0) begin
                    out_rvalid = 1'b1;
                    out_rdata  = data;
                    rq.push_back('{win, data});
                end
                @(posedge clk); #1;
                out_gnt    = 1'b0;
                out_rvalid = 1'b0;
                out_rdata  = $urandom;
                if (rd > 0) begin
                    repeat (rd - 1) begin @(posedge clk); #1; end
                    out_rvalid = 1'b1;
                    out_rdata  = data;
                    rq.push_back('{win, data});
                    @(posedge clk); #1;
                    out_rvalid = 1'b0;
                    out_rdata  = $urandom;
                end
                idx++;
            end else begin
                req_prev = {p1_req, p0_req};
            end
        end
    endtask

    task automatic run_monitor();
        logic prev_fire;
        int   e;
        rsp_t r;
        prev_fire = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_fire) begin
                chk("out_cmd_cleared", {out_req, out_we, out_addr, out_be, out_wdata}, 64'd0);
            end
            prev_fire = out_req && out_gnt;
            if (p0_gnt || p1_gnt) begin
                if (gq.size() == 0) begin
                    chk("gnt_unexpected", {p1_gnt, p0_gnt}, 64'd0);
                end else begin
                    e = gq.pop_front();
                    chk("gnt_port", {p1_gnt, p0_gnt}, (e == 0) ? 64'd1 : 64'd2);
                end
            end
            if (p0_rvalid || p1_rvalid) begin
                if (rq.size() == 0) begin
                    chk("rvalid_unexpected", {p1_rvalid, p0_rvalid}, 64'd0);
                end else begin
                    r = rq.pop_front();
                    chk("rvalid_port", {p1_rvalid, p0_rvalid}, (r.port == 0) ? 64'd1 : 64'd2);
                    chk("rdata_winner", (r.port == 0) ? p0_rdata : p1_rdata, r.data);
                    chk("rdata_loser", (r.port == 0) ? p1_rdata : p0_rdata, 64'd0);
                end
            end
            if (done0 && done1) break;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        done0 = 1'b0; done1 = 1'b0;
        m_gcnt[0] = 0; m_gcnt[1] = 0;
        rst_n = 1'b0;
        set_port(0, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0);
        set_port(1, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0);
        out_gnt = 1'b0; out_rvalid = 1'b0; out_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_req", out_req, 1'b0);
        chk("rst_out_cmd", {out_we, out_addr, out_be, out_wdata}, 64'd0);
        chk("rst_p_gnt_rvalid", {p1_gnt, p1_rvalid, p0_gnt, p0_rvalid}, 64'd0);
        chk("rst_p_rdata", {p1_rdata, p0_rdata}, 64'd0);
        rst_n = 1'b1;

        // Reset while waiting for the response: late rvalid must be dropped.
        @(posedge clk); #1;
        set_port(0, 1'b1, 16'h0200, 1'b0, 4'hF, 32'h0);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = out_req;
        end
        chk("rst_case_out_req", seen, 1'b1);
        chk("rst_case_out_addr", out_addr, 16'h0200);
        @(posedge clk); #1;
        out_gnt = 1'b1;
        @(negedge clk);
        chk("rst_case_p0_gnt", {p1_gnt, p0_gnt}, 64'd1);
        @(posedge clk); #1;
        out_gnt = 1'b0;
        set_port(0, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {out_req, p1_gnt, p1_rvalid, p0_gnt, p0_rvalid}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_rvalid = 1'b1;
        out_gnt    = 1'b1;
        out_rdata  = 32'hCAFEF00D;
        @(negedge clk);
        chk("late_rvalid_dropped", {out_req, p1_gnt, p1_rvalid, p0_gnt, p0_rvalid}, 64'd0);
        chk("late_rdata_dropped", {p1_rdata, p0_rdata}, 64'd0);
        @(posedge clk); #1;
        out_rvalid = 1'b0;
        out_gnt    = 1'b0;
        out_rdata  = 32'h0;
        @(posedge clk); #1;

        m_last = 1;
        fork
            run_requester(0);
            run_requester(1);
            run_memory();
            run_monitor();
        join

        chk("gq_drained", gq.size(), 64'd0);
        chk("rq_drained", rq.size(), 64'd0);
        chk("order_len", {63'd0, ord.size() >= 4}, 64'd1);
        if (ord.size() >= 4) begin
            chk("order_0", ord[0], 64'd0);
            chk("order_1", ord[1], 64'd1);
            chk("order_2", ord[2], 64'd0);
            chk("order_3", ord[3], 64'd1);
        end
`ifdef SAYURU_ARB_PERF_EN
        chk("grant_count_p0", gc0, m_gcnt[0]);
        chk("grant_count_p1", gc1, m_gcnt[1]);
        chk("contention_ge4", {63'd0, cc >= 32'd4}, 64'd1);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
